tmds_channel_decoder: RTL and testbench



---
 rtl/tmds_pkg.sv | 19 +
 rtl/tmds_word_decode.sv | 35 +++
 rtl/tmds_channel_decoder.sv | 159 +++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS control tokens, decoder FSM states and default parameters
package tmds_pkg;

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  localparam int TOKEN_LOCK_DEFAULT    = 16;
  localparam int SEARCH_WINDOW_DEFAULT = 4096;
  localparam int SLIP_SETTLE_DEFAULT   = 4;

  typedef enum logic [1:0] {
    SEARCH    = 2'd0,
    SLIP_WAIT = 2'd1,
    LOCKED    = 2'd2
  } tmds_state_e;

endpackage

// File: rtl/tmds_word_decode.sv
// rtl/tmds_word_decode.sv - combinational TMDS 10b->8b data decode with control-token detect
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] i_word,
  output logic [7:0] o_data,
  output logic [1:0] o_control,
  output logic       o_is_token
);

  logic [7:0] q;

  always_comb begin
    q      = i_word[9] ? ~i_word[7:0] : i_word[7:0];
    o_data = '0;
    o_data[0] = q[0];
    // bit 8 says whether the encoder chained with XOR or XNOR
    for (int i = 1; i < 8; i++) begin
      o_data[i] = i_word[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  always_comb begin
    o_control  = 2'b00;
    o_is_token = 1'b1;
    case (i_word)
      TOKEN_C00: o_control = 2'b00;
      TOKEN_C01: o_control = 2'b01;
      TOKEN_C10: o_control = 2'b10;
      TOKEN_C11: o_control = 2'b11;
      default:   o_is_token = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - per-channel TMDS receiver: token-based word alignment, lock FSM and decode
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int TOKEN_LOCK    = TOKEN_LOCK_DEFAULT,
  parameter int SEARCH_WINDOW = SEARCH_WINDOW_DEFAULT,
  parameter int SLIP_SETTLE   = SLIP_SETTLE_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_tmds,
  output logic [7:0] o_data,
  output logic [1:0] o_control,
  output logic       o_de,
  output logic       o_locked,
  output logic       o_bitslip,
  output logic       o_lock_lost
);

  localparam int TOK_W = $clog2(TOKEN_LOCK + 1);
  localparam int WIN_W = $clog2(SEARCH_WINDOW + 1);
  localparam int SET_W = $clog2(SLIP_SETTLE + 1);
  localparam logic [TOK_W-1:0] TOK_MAX = TOK_W'(TOKEN_LOCK);
  localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(SEARCH_WINDOW);
  localparam logic [SET_W-1:0] SET_MAX = SET_W'(SLIP_SETTLE);

  logic [9:0]       word_q, word_d;
  tmds_state_e      state_q, state_d;
  logic [TOK_W-1:0] tok_cnt_q, tok_cnt_d, tok_inc;
  logic [WIN_W-1:0] timer_q, timer_d, timer_inc;
  logic [SET_W-1:0] settle_q, settle_d, settle_inc;
  logic [7:0]       data_q, data_d;
  logic [1:0]       control_q, control_d;
  logic             de_q, de_d;
  logic             locked_q, locked_d;
  logic             bitslip_q, bitslip_d;
  logic             lock_lost_q, lock_lost_d;

  logic [7:0] dec_data;
  logic [1:0] dec_control;
  logic       dec_is_token;

  tmds_word_decode u_word_decode (
    .i_word     (word_q),
    .o_data     (dec_data),
    .o_control  (dec_control),
    .o_is_token (dec_is_token)
  );

  always_comb begin
    word_d      = i_tmds;
    state_d     = state_q;
    tok_cnt_d   = tok_cnt_q;
    timer_d     = timer_q;
    settle_d    = settle_q;
    bitslip_d   = 1'b0;
    lock_lost_d = 1'b0;
    tok_inc     = (tok_cnt_q == TOK_MAX) ? tok_cnt_q : tok_cnt_q + 1'b1;
    timer_inc   = (timer_q == WIN_MAX) ? timer_q : timer_q + 1'b1;
    settle_inc  = (settle_q == SET_MAX) ? settle_q : settle_q + 1'b1;

    case (state_q)
      SEARCH: begin
        tok_cnt_d = dec_is_token ? tok_inc : '0;
        timer_d   = timer_inc;
        // lock is tested first so it wins over a coincident window expiry
        if (tok_cnt_d == TOK_MAX) begin
          state_d   = LOCKED;
          tok_cnt_d = '0;
          timer_d   = '0;
        end else if (timer_d == WIN_MAX) begin
          state_d   = SLIP_WAIT;
          bitslip_d = 1'b1;
          tok_cnt_d = '0;
          timer_d   = '0;
          settle_d  = '0;
        end
      end
      SLIP_WAIT: begin
        tok_cnt_d = '0;
        timer_d   = '0;
        settle_d  = settle_inc;
        if (settle_d == SET_MAX) begin
          state_d  = SEARCH;
          settle_d = '0;
        end
      end
      LOCKED: begin
        timer_d = dec_is_token ? '0 : timer_inc;
        if (timer_d == WIN_MAX) begin
          state_d     = SEARCH;
          lock_lost_d = 1'b1;
          timer_d     = '0;
          tok_cnt_d   = '0;
        end
      end
      default: begin
        state_d   = SEARCH;
        tok_cnt_d = '0;
        timer_d   = '0;
        settle_d  = '0;
      end
    endcase
  end

  // Stage-2 outputs follow the state this word moves the FSM into
  always_comb begin
    data_d    = 8'h00;
    control_d = 2'b00;
    de_d      = 1'b0;
    locked_d  = 1'b0;
    if (state_d == LOCKED) begin
      locked_d = 1'b1;
      if (dec_is_token) begin
        control_d = dec_control;
      end else begin
        de_d      = 1'b1;
        data_d    = dec_data;
        control_d = control_q;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      word_q      <= '0;
      state_q     <= SEARCH;
      tok_cnt_q   <= '0;
      timer_q     <= '0;
      settle_q    <= '0;
      data_q      <= '0;
      control_q   <= '0;
      de_q        <= 1'b0;
      locked_q    <= 1'b0;
      bitslip_q   <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      word_q      <= word_d;
      state_q     <= state_d;
      tok_cnt_q   <= tok_cnt_d;
      timer_q     <= timer_d;
      settle_q    <= settle_d;
      data_q      <= data_d;
      control_q   <= control_d;
      de_q        <= de_d;
      locked_q    <= locked_d;
      bitslip_q   <= bitslip_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign o_data      = data_q;
  assign o_control   = control_q;
  assign o_de        = de_q;
  assign o_locked    = locked_q;
  assign o_bitslip   = bitslip_q;
  assign o_lock_lost = lock_lost_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - randomized bench for tmds_channel_decoder against a behavioural model
module tb_tmds_channel_decoder;

  localparam int TL = 16;
  localparam int SW = 64;
  localparam int SS = 4;

  localparam int HUNT   = 0;
  localparam int SETTLE = 1;
  localparam int LOCK   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] tmds = '0;
  logic [7:0] o_data;
  logic [1:0] o_control;
  logic       o_de, o_locked, o_bitslip, o_lock_lost;

  always #5 clk = ~clk;

  tmds_channel_decoder #(
    .TOKEN_LOCK    (TL),
    .SEARCH_WINDOW (SW),
    .SLIP_SETTLE   (SS)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_tmds      (tmds),
    .o_data      (o_data),
    .o_control   (o_control),
    .o_de        (o_de),
    .o_locked    (o_locked),
    .o_bitslip   (o_bitslip),
    .o_lock_lost (o_lock_lost)
  );

  logic [9:0] tok_tbl [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int tok_index(input logic [9:0] w);
    for (int i = 0; i < 4; i++) if (w == tok_tbl[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    logic [7:0] q, d;
    q = w[9] ? ~w[7:0] : w[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  // token 00 seen through a deserializer whose word boundary is off by 'off' bits
  function automatic logic [9:0] rot(input int off);
    logic [9:0] t, r;
    t = tok_tbl[0];
    for (int i = 0; i < 10; i++) r[i] = t[(i + off) % 10];
    return r;
  endfunction

  int         m_mode, m_run, m_age, m_settle;
  logic [9:0] m_held;
  logic [7:0] e_data;
  logic [1:0] e_ctrl;
  logic       e_de, e_locked, e_slip, e_lost;

  task automatic model_reset();
    m_mode = HUNT; m_run = 0; m_age = 0; m_settle = 0; m_held = '0;
    e_data = '0; e_ctrl = '0; e_de = 0; e_locked = 0; e_slip = 0; e_lost = 0;
  endtask

  task automatic model_clock(input logic [9:0] sampled);
    int idx;
    idx = tok_index(m_held);
    e_slip = 0;
    e_lost = 0;
    case (m_mode)
      HUNT: begin
        m_run = (idx >= 0) ? ((m_run < TL) ? m_run + 1 : TL) : 0;
        if (m_age < SW) m_age++;
        if (m_run == TL) begin
          m_mode = LOCK; m_run = 0; m_age = 0;
        end else if (m_age == SW) begin
          m_mode = SETTLE; e_slip = 1; m_run = 0; m_age = 0; m_settle = 0;
        end
      end
      SETTLE: begin
        m_settle++;
        if (m_settle == SS) begin m_mode = HUNT; m_settle = 0; end
      end
      default: begin
        if (idx >= 0) m_age = 0;
        else if (m_age < SW) m_age++;
        if (m_age == SW) begin m_mode = HUNT; e_lost = 1; m_age = 0; m_run = 0; end
      end
    endcase
    if (m_mode == LOCK) begin
      e_locked = 1;
      if (idx >= 0) begin e_de = 0; e_data = 0; e_ctrl = idx[1:0]; end
      else begin e_de = 1; e_data = ref_decode(m_held); end
    end else begin
      e_locked = 0; e_de = 0; e_data = 0; e_ctrl = 0;
    end
    m_held = sampled;
  endtask

  int cyc = 0;
  int slips = 0;
  int losts = 0;
  int last_slip = -1;

  task automatic cycle(input logic [9:0] w);
    tmds = w;
    @(posedge clk);
    model_clock(w);
    #1;
    cyc++;
    check("data", o_data, e_data);
    check("control", o_control, e_ctrl);
    check("de", o_de, e_de);
    check("locked", o_locked, e_locked);
    check("bitslip", o_bitslip, e_slip);
    check("lock_lost", o_lock_lost, e_lost);
    check("pulse_overlap", o_bitslip & o_lock_lost, 1'b0);
    if (o_bitslip) begin
      if (last_slip >= 0) check("slip_gap", (cyc - last_slip) >= (SS + SW), 1'b1);
      last_slip = cyc;
      slips++;
    end
    if (o_lock_lost) losts++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_data", o_data, 8'h00);
    check("rst_control", o_control, 2'b00);
    check("rst_de", o_de, 1'b0);
    check("rst_locked", o_locked, 1'b0);
    check("rst_bitslip", o_bitslip, 1'b0);
    check("rst_lock_lost", o_lock_lost, 1'b0);
    #20;
    rst = 1'b0;
    slips = 0; losts = 0; last_slip = -1;
  endtask

  task automatic lock_aligned();
    for (int i = 0; i < TL; i++) cycle(tok_tbl[0]);
    check("lock_not_early", o_locked, 1'b0);
    cycle(tok_tbl[0]);
    check("lock_on_time", o_locked, 1'b1);
    check("lock_control", o_control, 2'b00);
    check("lock_de", o_de, 1'b0);
    check("lock_no_slip", slips, 0);
  endtask

  initial begin
    #1;
    check("por_locked", o_locked, 1'b0);
    check("por_de", o_de, 1'b0);

    do_reset();
    lock_aligned();

    cycle(tok_tbl[3]);
    cycle(10'h100);
    cycle(10'h2FF);
    check("dec_100_de", o_de, 1'b1);
    check("dec_100_data", o_data, 8'h00);
    check("dec_100_ctrl", o_control, 2'b11);
    cycle(tok_tbl[3]);
    check("dec_2ff_data", o_data, 8'hFE);
    check("dec_2ff_ctrl", o_control, 2'b11);
    cycle(tok_tbl[3]);
    check("tok_after_data_de", o_de, 1'b0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) cycle(tok_tbl[$urandom_range(0, 3)]);
      else cycle(10'($urandom));
    end
    check("random_kept_lock", o_locked, 1'b1);

    for (int i = 0; i < SW + 3; i++) cycle(10'h100);
    check("loss_pulses", losts, 1);
    check("loss_locked", o_locked, 1'b0);
    check("loss_de", o_de, 1'b0);

    for (int r = 0; r < 2; r++) begin
      int k, off, guard;
      k = $urandom_range(1, 9);
      do_reset();
      off = k;
      guard = 0;
      while (!o_locked && guard < 1500) begin
        cycle(rot(off));
        if (o_bitslip) off = (off + 1) % 10;
        guard++;
      end
      check("misalign_locked", o_locked, 1'b1);
      check("misalign_slips", slips, (10 - k) % 10);
    end

    do_reset();
    lock_aligned();
    for (int i = 0; i < 5; i++) cycle(10'($urandom_range(0, 255)) | 10'h100);
    check("pre_rst_de", o_de, 1'b1);
    do_reset();
    for (int i = 0; i < TL; i++) cycle(tok_tbl[1]);
    check("fresh_not_early", o_locked, 1'b0);
    cycle(tok_tbl[1]);
    check("fresh_lock", o_locked, 1'b1);
    check("fresh_control", o_control, 2'b01);

    do_reset();
    for (int i = 1; i <= 47; i++) cycle(10'h100);
    for (int i = 48; i <= 63; i++) cycle(tok_tbl[2]);
    cycle(tok_tbl[2]);
    check("tie_locked", o_locked, 1'b1);
    check("tie_no_slip", slips, 0);
    for (int i = 0; i < 10; i++) cycle(tok_tbl[2]);
    check("tie_still_no_slip", slips, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
